// File: rtl/mms_seq_ctrl_pkg.sv
// Shared types and constants for the min/max sequencing controller.
package mms_seq_ctrl_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned SLOTS   = 3;
    localparam int unsigned FILL_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic SEL_MIN = 1'b1;
    localparam logic SEL_MAX = 1'b0;

endpackage

// File: rtl/mms_seq_ctrl_cmp.sv
// Combinational 4-operand unsigned min/max: two-level tree of pairwise compares.
module mms4_cmp
    import mms_seq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] op0,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [DATA_W-1:0] op3,
    output logic [DATA_W-1:0] res_c
);

    logic [DATA_W-1:0] lvl0_c;
    logic [DATA_W-1:0] lvl1_c;

    // Ties return either operand, which are equal, so the choice is irrelevant.
    function automatic logic [DATA_W-1:0] pick(input logic s,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        if (s == SEL_MAX) begin
            return (a >= b) ? a : b;
        end
        return (a <= b) ? a : b;
    endfunction

    // Pairwise first level, then combine the two winners.
    always_comb begin
        lvl0_c = pick(sel, op0, op1);
        lvl1_c = pick(sel, op2, op3);
        res_c  = pick(sel, lvl0_c, lvl1_c);
    end

endmodule

// File: rtl/mms_seq_ctrl.sv
// Packet min/max reducer: buffers numbers three at a time and folds each group
// into a running accumulator through one shared 4-input compare unit.
module mms_seq_ctrl
    import mms_seq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              select,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e              state_q, state_d;
    logic                sel_q, sel_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   slot_q [SLOTS];
    logic [DATA_W-1:0]   slot_d [SLOTS];
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   ident_c;
    logic [DATA_W-1:0]   op_c [SLOTS];
    logic [DATA_W-1:0]   cmp_res_c;
    logic                xfer_c;

    // Identity operand for the latched mode; also pads unwritten slots.
    always_comb begin
        ident_c = (sel_q == SEL_MIN) ? '1 : '0;
        for (int i = 0; i < SLOTS; i++) begin
            op_c[i] = (FILL_W'(i) < fill_q) ? slot_q[i] : ident_c;
        end
    end

    mms4_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .sel   (sel_q),
        .op0   (acc_q),
        .op1   (op_c[0]),
        .op2   (op_c[1]),
        .op3   (op_c[2]),
        .res_c (cmp_res_c)
    );

    // Next-state and datapath updates; registered outputs follow the next state.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        acc_d          = acc_q;
        slot_d         = slot_q;
        fill_d         = fill_q;
        count_d        = count_q;
        last_d         = last_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        xfer_c         = in_valid && in_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d   = select;
                    acc_d   = (select == SEL_MIN) ? '1 : '0;
                    fill_d  = '0;
                    count_d = '0;
                    last_d  = 1'b0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (xfer_c) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (fill_q == FILL_W'(i)) begin
                            slot_d[i] = in_data;
                        end
                    end
                    fill_d  = fill_q + FILL_W'(1);
                    count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
                    if ((fill_q == FILL_W'(SLOTS - 1)) || in_last) begin
                        last_d  = in_last;
                        state_d = ST_REDUCE;
                    end
                end
            end
            ST_REDUCE: begin
                acc_d   = cmp_res_c;
                fill_d  = '0;
                state_d = last_q ? ST_DONE : ST_FILL;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_FILL);
        busy_d     = (state_d != ST_IDLE);
        if (state_d == ST_DONE) begin
            result_d       = acc_d;
            result_valid_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            sel_q          <= SEL_MAX;
            acc_q          <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            fill_q         <= '0;
            count_q        <= '0;
            last_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            acc_q          <= acc_d;
            slot_q         <= slot_d;
            fill_q         <= fill_d;
            count_q        <= count_d;
            last_q         <= last_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign count        = count_q;

endmodule

// File: tb/tb_mms_seq_ctrl.sv
// Scoreboard bench for mms_seq_ctrl: expected {result,count} queued per packet,
// popped and compared when result_valid pulses.
module tb_mms_seq_ctrl;

    typedef struct {
        logic [7:0] res;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       select = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;
    logic [7:0] count;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   rv_cyc = -1;
    int   reduce_cnt = 0;
    logic rv_prev = 1'b0;

    exp_t       exp_q[$];
    logic [7:0] pkt[$];

    mms_seq_ctrl #(
        .DATA_W (8),
        .CNT_W  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .select       (select),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .count        (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output monitor: scoreboard pop, single-pulse check, REDUCE-cycle counting.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy && !in_ready && !result_valid) reduce_cnt++;
            if (result_valid) begin
                exp_t ex;
                rv_cyc = cyc;
                total++;
                if (rv_prev) begin
                    bad++;
                    $display("FAIL rv_pulse: result_valid high two cycles in a row at cycle %0d", cyc);
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rv_unexpected: result_valid with nothing expected, result=%0d", result);
                end else begin
                    ex = exp_q.pop_front();
                    total++;
                    if (result !== ex.res) begin
                        bad++;
                        $display("FAIL result: got %0d expected %0d", result, ex.res);
                    end
                    total++;
                    if (count !== ex.cnt) begin
                        bad++;
                        $display("FAIL count: got %0d expected %0d", count, ex.cnt);
                    end
                end
            end
        end
        rv_prev = result_valid && !reset;
    end

    // Drives one packet from pkt[] and waits (bounded) for its result.
    task automatic drive_packet(input logic sel, input bit gaps, input bit disturb);
        exp_t       ex;
        logic [7:0] e;
        int         n;
        int         waitc;
        int         busy_drop;
        bit         hs;
        bit         done;
        bit         aborted;
        n = pkt.size();
        busy_drop = 0;
        aborted = 1'b0;
        e = sel ? 8'hFF : 8'h00;
        foreach (pkt[i]) begin
            if (sel ? (pkt[i] < e) : (pkt[i] > e)) e = pkt[i];
        end
        ex.res = e;
        ex.cnt = (n > 255) ? 8'hFF : 8'(n);
        exp_q.push_back(ex);

        @(posedge clk); #1;
        start = 1'b1;
        select = sel;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n && !aborted; i++) begin
            in_data = pkt[i];
            in_last = (i == n - 1);
            if (disturb && i == 1) begin
                start = 1'b1;
                select = ~sel;
            end
            waitc = 0;
            done = 1'b0;
            while (!done && !aborted) begin
                in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                hs = in_valid && in_ready;
                if (disturb && !busy) busy_drop++;
                @(posedge clk); #1;
                start = 1'b0;
                if (hs) done = 1'b1;
                else if (++waitc > 100) aborted = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        waitc = 0;
        while (exp_q.size() != 0 && waitc < 30) begin
            @(posedge clk); #1;
            waitc++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL timeout: %0d results still pending (expected result %0d)", exp_q.size(), ex.res);
            exp_q.delete();
        end
        if (disturb) begin
            total++;
            if (busy_drop != 0) begin
                bad++;
                $display("FAIL busy_hold: busy low %0d cycles mid-packet, expected 0", busy_drop);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL rst_result: got %0d expected 0", result); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_result_valid: got %b expected 0", result_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        total++; if (count !== 8'h00) begin bad++; $display("FAIL rst_count: got %0d expected 0", count); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_max();
        int r0;
        pkt = '{8'd5, 8'd200, 8'd17, 8'd99};
        r0 = reduce_cnt;
        drive_packet(1'b0, 1'b0, 1'b0);
        total++;
        if (rv_cyc - start_cyc !== 7) begin
            bad++;
            $display("FAIL max_latency: result_valid at cycle %0d after start, expected 7", rv_cyc - start_cyc);
        end
        total++;
        if (reduce_cnt - r0 !== 2) begin
            bad++;
            $display("FAIL max_reduces: got %0d expected 2", reduce_cnt - r0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (result !== 8'd200 || busy !== 1'b0) begin
            bad++;
            $display("FAIL max_hold: result=%0d busy=%b expected 200/0", result, busy);
        end
    endtask

    task automatic test_min();
        int r0;
        pkt = '{8'd40, 8'd3, 8'd250, 8'd3, 8'd77, 8'd9};
        r0 = reduce_cnt;
        drive_packet(1'b1, 1'b0, 1'b0);
        total++;
        if (reduce_cnt - r0 !== 2) begin
            bad++;
            $display("FAIL min_reduces: got %0d expected 2", reduce_cnt - r0);
        end
    endtask

    task automatic test_padding();
        pkt = '{8'h80};
        drive_packet(1'b1, 1'b0, 1'b0);
        pkt = '{8'h00, 8'h00};
        drive_packet(1'b0, 1'b0, 1'b0);
        pkt = '{8'h90, 8'h11, 8'h42, 8'h7F, 8'h12};
        drive_packet(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        pkt = '{8'd10, 8'd250, 8'd255};
        drive_packet(1'b0, 1'b1, 1'b0);
        pkt = '{8'd60, 8'd61, 8'd59, 8'd200, 8'd58, 8'd90, 8'd91};
        drive_packet(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_ignored();
        pkt = '{8'd12, 8'd7, 8'd99, 8'd34, 8'd8};
        drive_packet(1'b0, 1'b0, 1'b1);
        pkt = '{8'd12, 8'd7, 8'd99, 8'd34, 8'd8};
        drive_packet(1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start: busy=%b after packet, expected 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        pkt = '{8'd55, 8'd220};
        drive_packet(1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; select = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 8'd33;
        @(posedge clk); #1;
        in_data = 8'd44;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL mid_rst_result: got %0d expected 0", result); end
        total++; if (count !== 8'h00) begin bad++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_rv: got %b expected 0", result_valid); end
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_vs_reset: busy=%b expected 0", busy); end
        pkt = '{8'd9, 8'd4, 8'd200, 8'd150};
        drive_packet(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        pkt.delete();
        for (int i = 0; i < 300; i++) pkt.push_back(8'($urandom_range(20, 200)));
        pkt[280] = 8'd5;
        drive_packet(1'b1, 1'b0, 1'b0);
        pkt.delete();
        for (int i = 0; i < 290; i++) pkt.push_back(8'($urandom_range(0, 180)));
        pkt[270] = 8'd231;
        drive_packet(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 10);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
            drive_packet(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_min();
        test_padding();
        test_backpressure();
        test_ignored();
        test_mid_reset();
        test_saturation();
        test_random();
        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
